wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone initiator that turns single-word command requests from an on-chip host (UART debug bridge, sequencer) into classic Wishbone read/write cycles. It drives the shared bus that the GPIO and other peripheral register slaves sit on. It returns read data plus an error flag on a response handshake. An optional watchdog terminates cycles that no slave acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for wb_ack_i before aborting; legal range 1..65535.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge
- wb_rst_i  input  1  reset; asynchronous, active-high
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  command accepted on edge where valid&&ready
- cmd_adr_i  input  32  byte address
- cmd_dat_i  input  32  write data
- cmd_sel_i  input  4  byte selects
- cmd_we_i  input  1  1 = write, 0 = read
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  response consumed on edge where valid&&ready
- rsp_dat_o  output  32  read data; 0 for writes and aborted cycles
- rsp_err_o  output  1  1 = cycle aborted by timeout
- wb_adr_o, wb_dat_o  output  32  bus address / write data
- wb_sel_o  output  4  bus byte selects
- wb_we_o, wb_cyc_o, wb_stb_o  output  1  bus controls
- wb_dat_i  input  32  bus read data
- wb_ack_i  input  1  slave acknowledge

## Operation
- States IDLE, BUS, RESP; reset state IDLE.
- IDLE: cmd_ready_o = 1 (forced 0 while wb_rst_i high). On cmd_valid_i: latch adr/dat/sel/we onto wb_* outputs, set cyc=stb=1, clear timeout counter, go BUS.
- BUS: hold all wb_* outputs stable. On edge with wb_ack_i=1: cyc=stb=we=0; rsp_dat_o = wb_dat_i if read, else 0; rsp_err_o = 0; rsp_valid_o = 1; go RESP.
- BUS timeout (macro enabled): counter increments each BUS edge without ack; on edge where counter reaches TIMEOUT_CYCLES-1 with no ack: cyc=stb=we=0, rsp_dat_o = 0, rsp_err_o = 1, go RESP. Ack on same edge wins (normal completion).
- RESP: rsp_valid_o held with stable data until rsp_ready_i; on that edge rsp_valid_o = 0, go IDLE.
- wb_ack_i ignored outside BUS (slaves with registered ack may hold ack one cycle after stb drops; this must not complete anything).
- Reset (any state, any time): state IDLE; all outputs 0 immediately, asynchronously; cmd_ready_o 0 until reset deasserts; in-flight cycle dropped without response.

## Timing
- Command accepted edge N → cyc/stb high from N to ack-edge M.
- Response valid from edge M; for a registered-ack slave, M = N+2 → rsp_valid_o after N+2.
- Minimum cycle-to-cycle spacing: response consumed edge R → IDLE; next command accepted at R+1 earliest. At least one cycle with cyc=0 between bus cycles.
- Timeout abort: rsp_valid_o rises exactly TIMEOUT_CYCLES edges after the edge cyc rose.
- rsp_ready_i may already be high when rsp_valid_o rises: response is consumed on the first RESP edge, so RESP lasts one cycle.

## Configuration
- WB_HOST_MASTER_TIMEOUT_EN defined: timeout counter (16 bits) and abort path built; rsp_err_o as above.
- Not defined: no counter; BUS waits indefinitely for ack; rsp_err_o tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Write/read-back with the GPIO slave at 0x0100_0000: write 0xA5A5_0F0F to 0x0100_0004, then read 0x0100_0004 → response 1 has rsp_dat_o=0, rsp_err_o=0; response 2 has rsp_dat_o=0xA5A5_0F0F; gpio_o=0xA5A5_0F0F; rsp_valid_o rises 2 edges after each accept.
- Unmapped read at 0x0200_0000, TIMEOUT_CYCLES=8, macro on → cyc high exactly 8 cycles, then rsp_err_o=1 and rsp_dat_o=0; next command to 0x0100_0000 completes with rsp_err_o=0.
- Late-ack race: slave model asserts ack on the exact timeout edge → rsp_err_o=0, read data returned.
- Back-pressure: hold rsp_ready_i=0 for 5 cycles after a read of 0x0100_0008 → rsp_valid_o and rsp_dat_o stable; cmd_ready_o=0 throughout; cyc=0 throughout.
- Stale ack: registered-ack slave with rsp_ready_i tied 1 and back-to-back commands → exactly one response per command; no cycle completes with zero-cycle stb.
- Reset mid-BUS: assert wb_rst_i between clock edges while cyc=1 → cyc, stb, and rsp_valid_o go 0 before the next edge; no response is produced after release.

Source files
------------

// File: rtl/wb_host_master.sv
// wb_host_master: single-word Wishbone classic initiator for on-chip hosts.
// Accepts one command (read or write), runs one Wishbone cycle, and returns
// read data plus an error flag on a valid/ready response handshake.
//
// Optional build macro: WB_HOST_MASTER_TIMEOUT_EN
//   defined   -> 16-bit watchdog aborts a cycle that is not acknowledged
//                within TIMEOUT_CYCLES bus cycles (rsp_err_o = 1)
//   undefined -> the bus cycle waits for wb_ack_i indefinitely, rsp_err_o = 0
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   cmd_*                  command channel (valid/ready, adr, dat, sel, we)
//   rsp_*                  response channel (valid/ready, read data, error)
//   wb_*                   Wishbone classic master bus
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic        cmd_we_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;

  // Counter value on the edge that aborts: rsp_valid_o then rises exactly
  // TIMEOUT_CYCLES edges after the edge that raised cyc.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the timeout edge completes normally.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        // wb_ack_i is deliberately ignored here (stale registered ack).
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;

  // Ready is a state decode, gated so it drops the instant reset asserts.
  assign cmd_ready_o = (state_q == IDLE) && !wb_rst_i;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LAST;
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// Testbench for wb_host_master: GPIO-style register slave with registered
// ack (optionally held while stb is high), a directed-ack hook for the
// timeout race, and a response scoreboard queue.
module tb_wb_host_master;

  localparam int unsigned TO = 8;
  localparam logic [31:0] RACE_DAT = 32'h1234_5678;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam int HANG = 3;
`else
  localparam int HANG = 20;
`endif

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic        clk, rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  wb_host_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_sel_i  (cmd_sel_i),
    .cmd_we_i   (cmd_we_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO register slave at 0x01xx_xxxx with registered ack.
  logic        slv_ack, race_ack, sticky, hit;
  logic [1:0]  idx;
  logic [31:0] mem [4];
  logic [31:0] gpio_o;
  assign hit    = (wb_adr_o[31:24] == 8'h01);
  assign idx    = wb_adr_o[3:2];
  assign gpio_o = mem[1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack <= 1'b0;
    end else begin
      slv_ack <= wb_cyc_o && wb_stb_o && hit && (sticky || !slv_ack);
      if (wb_cyc_o && wb_stb_o && wb_we_o && hit && slv_ack) mem[idx] <= wb_dat_o;
    end
  end

  assign wb_ack_i = slv_ack | race_ack;
  assign wb_dat_i = race_ack ? RACE_DAT : (slv_ack ? mem[idx] : 32'hDEAD_BEEF);

  // Handshake counters.
  int n_acc = 0, n_rsp = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_valid_i && cmd_ready_o) n_acc++;
      if (rsp_valid_o && rsp_ready_i) n_rsp++;
    end
  end

  exp_t exp_q[$];
  int   checks = 0, errors = 0, n_push = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge and return just after the accepting edge.
  task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       input logic [31:0] edat, input logic eerr, input bit push);
    int n = 0;
    exp_t e;
    cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = 4'hF; cmd_we_i = we;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready_o) begin
      check("accept", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.dat = edat; e.err = eerr;
      exp_q.push_back(e);
      n_push++;
    end
    #1 cmd_valid_i = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally consume.
  task automatic wait_rsp(input string tag, input int elat, input int ecyc, input bit consume);
    int edges = 0, cyc_n = 0;
    exp_t e;
    @(negedge clk);
    if (wb_cyc_o) cyc_n++;
    while (!rsp_valid_o && edges < 40) begin
      @(negedge clk); edges++;
      if (wb_cyc_o) cyc_n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    if (!rsp_valid_o) return;
    check({tag, "_lat"}, 32'(edges), 32'(elat));
    check({tag, "_cyc"}, 32'(cyc_n), 32'(ecyc));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{dat: 32'hxxxx_xxxx, err: 1'bx};
    check({tag, "_dat"}, rsp_dat_o, e.dat);
    check({tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
    if (consume) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done"}, 32'({rsp_valid_o, wb_cyc_o, cmd_ready_o}), 32'b001);
    end
  endtask

  initial begin
    int bad;
    exp_t e;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
    cmd_we_i = 1'b0; rsp_ready_i = 1'b0; race_ack = 1'b0; sticky = 1'b0;

    #1;
    check("rst_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o}), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(cmd_ready_o), 32'd1);

    // Write / read-back through the GPIO register.
    rsp_ready_i = 1'b1;
    issue(32'h0100_0004, 32'hA5A5_0F0F, 1'b1, 32'd0, 1'b0, 1'b1);
    wait_rsp("wr", 2, 2, 1'b1);
    check("gpio", gpio_o, 32'hA5A5_0F0F);
    issue(32'h0100_0004, 32'd0, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b1);
    wait_rsp("rd", 2, 2, 1'b1);
    issue(32'h0100_0008, 32'h5A5A_1234, 1'b1, 32'd0, 1'b0, 1'b1);
    wait_rsp("wr8", 2, 2, 1'b1);
    issue(32'h0100_0000, 32'h0000_00C3, 1'b1, 32'd0, 1'b0, 1'b1);
    wait_rsp("wr0", 2, 2, 1'b1);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    // Unmapped read: aborted after exactly TO cycles, then normal traffic resumes.
    issue(32'h0200_0000, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    wait_rsp("to", TO, TO, 1'b1);
    issue(32'h0100_0000, 32'd0, 1'b0, 32'h0000_00C3, 1'b0, 1'b1);
    wait_rsp("after_to", 2, 2, 1'b1);

    // Ack arriving on the timeout edge completes normally.
    issue(32'h0200_0000, 32'd0, 1'b0, RACE_DAT, 1'b0, 1'b1);
    repeat (TO) @(negedge clk);
    check("race_pre", 32'({wb_cyc_o, rsp_valid_o}), 32'b10);
    race_ack = 1'b1;
    @(posedge clk);
    #1 race_ack = 1'b0;
    @(negedge clk);
    check("race_valid", 32'(rsp_valid_o), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{dat: 32'hxxxx_xxxx, err: 1'bx};
    check("race_dat", rsp_dat_o, e.dat);
    check("race_err", 32'(rsp_err_o), 32'(e.err));
    @(posedge clk);
    @(negedge clk);
    check("race_done", 32'(rsp_valid_o), 32'd0);
`endif

    // Back-pressure: response held stable while rsp_ready_i is low.
    rsp_ready_i = 1'b0;
    issue(32'h0100_0008, 32'd0, 1'b0, 32'h5A5A_1234, 1'b0, 1'b1);
    wait_rsp("bp", 2, 2, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h5A5A_1234 ||
          cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", 32'({rsp_valid_o, cmd_ready_o}), 32'b01);

    // Slave holds ack while stb is high: ack lingers one cycle after completion.
    sticky = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h0100_000C, 32'hC0DE_0000 + 32'(i), 1'b1, 32'd0, 1'b0, 1'b1);
      wait_rsp("st_wr", 2, 2, 1'b1);
      issue(32'h0100_000C, 32'd0, 1'b0, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b1);
      wait_rsp("st_rd", 2, 2, 1'b1);
    end
    sticky = 1'b0;

    // Reset between edges while a cycle is waiting on an unmapped address.
    issue(32'h0200_0000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < HANG; i++) begin
      @(negedge clk);
      if (wb_cyc_o !== 1'b1 || rsp_valid_o !== 1'b0) bad++;
    end
    check("hang", 32'(bad), 32'd0);
    #2 rst = 1'b1;
    #1 check("mid_rst", 32'({wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
    end
    check("no_rsp_after_rst", 32'(bad), 32'd0);
    issue(32'h0100_0004, 32'd0, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b1);
    wait_rsp("recover", 2, 2, 1'b1);

    check("rsp_count", 32'(n_rsp), 32'(n_push));
    check("acc_count", 32'(n_acc), 32'(n_push + 1));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
